// File: rtl/bg_pkg.sv
// rtl/bg_pkg.sv - shared state encoding and distance-mode constants for the background remover
package bg_pkg;

   typedef enum logic [2:0] {
      QI   = 3'd0,
      QS   = 3'd1,
      QSD  = 3'd2,
      QBG  = 3'd3,
      QBGD = 3'd4
   } bg_state_t;

   localparam int DIST_PER_CHANNEL = 0;
   localparam int DIST_SUM         = 1;

endpackage

// File: rtl/bg_pixel_cmp.sv
// rtl/bg_pixel_cmp.sv - single-pixel distance test against the mean, replacing matches with the background colour
module bg_pixel_cmp
   import bg_pkg::*;
#(
   parameter int W         = 8,
   parameter int DIST_MODE = DIST_PER_CHANNEL
) (
   input  logic [W-1:0] pix_r,
   input  logic [W-1:0] pix_g,
   input  logic [W-1:0] pix_b,
   input  logic [W-1:0] exp_r,
   input  logic [W-1:0] exp_g,
   input  logic [W-1:0] exp_b,
   input  logic [W+1:0] threshold,
   input  logic [W-1:0] bg_r,
   input  logic [W-1:0] bg_g,
   input  logic [W-1:0] bg_b,
   output logic [W-1:0] res_r,
   output logic [W-1:0] res_g,
   output logic [W-1:0] res_b,
   output logic         match
);

   // W+2 bits keeps the three-channel sum (at most 3*(2**W-1)) from wrapping
   function automatic logic [W+1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
      return (a >= b) ? {2'b00, a - b} : {2'b00, b - a};
   endfunction

   logic [W+1:0] d_r, d_g, d_b;

   always_comb begin
      d_r = abs_diff(pix_r, exp_r);
      d_g = abs_diff(pix_g, exp_g);
      d_b = abs_diff(pix_b, exp_b);
      if (DIST_MODE == DIST_SUM) begin
         match = (d_r + d_g + d_b) <= threshold;
      end else begin
         match = (d_r <= threshold) && (d_g <= threshold) && (d_b <= threshold);
      end
      res_r = match ? bg_r : pix_r;
      res_g = match ? bg_g : pix_g;
      res_b = match ? bg_b : pix_b;
   end

endmodule

// File: rtl/bg_remover_stream_pe.sv
// rtl/bg_remover_stream_pe.sv - two-pass streaming background remover: frame mean, then replace near-mean pixels
module bg_remover_stream_pe
   import bg_pkg::*;
#(
   parameter int W         = 8,
   parameter int LANES     = 1,
   parameter int LOG2_NPIX = 4,
   parameter int DIST_MODE = DIST_PER_CHANNEL
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start_Sum,
   input  logic                 Start_BgRemoval,
   input  logic                 Ack,
   input  logic [W+1:0]         threshold,
   input  logic [W-1:0]         desired_bg_r,
   input  logic [W-1:0]         desired_bg_g,
   input  logic [W-1:0]         desired_bg_b,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LANES*W-1:0]   red_in,
   input  logic [LANES*W-1:0]   green_in,
   input  logic [LANES*W-1:0]   blue_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*W-1:0]   red_out,
   output logic [LANES*W-1:0]   green_out,
   output logic [LANES*W-1:0]   blue_out,
   output logic [W-1:0]         red_exp,
   output logic [W-1:0]         green_exp,
   output logic [W-1:0]         blue_exp,
   output logic                 exp_valid,
   output logic [LOG2_NPIX:0]   bg_count,
   output logic                 Qi,
   output logic                 Qs,
   output logic                 Qsd,
   output logic                 Qbg,
   output logic                 Qbgd
);

   localparam int NPIX  = 1 << LOG2_NPIX;
   localparam int BEATS = NPIX / LANES;
   localparam int AW    = W + LOG2_NPIX;
   localparam int CW    = LOG2_NPIX + 1;

   bg_state_t          state, state_n;
   logic [CW-1:0]      beat_cnt;
   logic [AW-1:0]      acc_r, acc_g, acc_b;
   logic [AW-1:0]      sum_r, sum_g, sum_b;
   logic [LANES*W-1:0] cmp_r, cmp_g, cmp_b;
   logic [LANES-1:0]   match;
   logic [CW-1:0]      match_cnt;
   logic               accept, last_beat, all_in;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      bg_pixel_cmp #(.W(W), .DIST_MODE(DIST_MODE)) u_cmp (
         .pix_r     (red_in[k*W +: W]),
         .pix_g     (green_in[k*W +: W]),
         .pix_b     (blue_in[k*W +: W]),
         .exp_r     (red_exp),
         .exp_g     (green_exp),
         .exp_b     (blue_exp),
         .threshold (threshold),
         .bg_r      (desired_bg_r),
         .bg_g      (desired_bg_g),
         .bg_b      (desired_bg_b),
         .res_r     (cmp_r[k*W +: W]),
         .res_g     (cmp_g[k*W +: W]),
         .res_b     (cmp_b[k*W +: W]),
         .match     (match[k])
      );
   end

   // Running sums including the beat currently on the bus, so the mean can latch on the last accept
   always_comb begin
      sum_r     = acc_r;
      sum_g     = acc_g;
      sum_b     = acc_b;
      match_cnt = '0;
      for (int k = 0; k < LANES; k++) begin
         sum_r     = sum_r + AW'(red_in[k*W +: W]);
         sum_g     = sum_g + AW'(green_in[k*W +: W]);
         sum_b     = sum_b + AW'(blue_in[k*W +: W]);
         match_cnt = match_cnt + CW'(match[k]);
      end
   end

   assign last_beat = (beat_cnt == CW'(BEATS - 1));
   assign all_in    = (beat_cnt == CW'(BEATS));
   assign accept    = in_valid && in_ready;

   always_ff @(posedge Clk) begin
      if (Reset) state <= QI;
      else       state <= state_n;
   end

   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      case (state)
         QI: begin
            if (Start_Sum)                         state_n = QS;
            else if (Start_BgRemoval && exp_valid) state_n = QBG;
         end
         QS: begin
            in_ready = 1'b1;
            if (in_valid && last_beat) state_n = QSD;
         end
         QBG: begin
            in_ready = (!out_valid || out_ready) && !all_in;
            if (all_in && out_valid && out_ready) state_n = QBGD;
         end
         QSD, QBGD: begin
            if (Ack) state_n = QI;
         end
         default: state_n = QI;
      endcase
   end

   assign Qi   = (state == QI);
   assign Qs   = (state == QS);
   assign Qsd  = (state == QSD);
   assign Qbg  = (state == QBG);
   assign Qbgd = (state == QBGD);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         beat_cnt  <= '0;
         acc_r     <= '0;
         acc_g     <= '0;
         acc_b     <= '0;
         red_exp   <= '0;
         green_exp <= '0;
         blue_exp  <= '0;
         exp_valid <= 1'b0;
         bg_count  <= '0;
         out_valid <= 1'b0;
         red_out   <= '0;
         green_out <= '0;
         blue_out  <= '0;
      end else begin
         case (state)
            QI: begin
               if (state_n == QS) begin
                  beat_cnt <= '0;
                  acc_r    <= '0;
                  acc_g    <= '0;
                  acc_b    <= '0;
               end
               if (state_n == QBG) begin
                  beat_cnt <= '0;
                  bg_count <= '0;
               end
            end
            QS: begin
               if (accept) begin
                  beat_cnt <= beat_cnt + CW'(1);
                  acc_r    <= sum_r;
                  acc_g    <= sum_g;
                  acc_b    <= sum_b;
                  if (last_beat) begin
                     red_exp   <= sum_r[AW-1:LOG2_NPIX];
                     green_exp <= sum_g[AW-1:LOG2_NPIX];
                     blue_exp  <= sum_b[AW-1:LOG2_NPIX];
                     exp_valid <= 1'b1;
                  end
               end
            end
            QBG: begin
               if (accept) begin
                  red_out   <= cmp_r;
                  green_out <= cmp_g;
                  blue_out  <= cmp_b;
                  out_valid <= 1'b1;
                  beat_cnt  <= beat_cnt + CW'(1);
                  bg_count  <= bg_count + match_cnt;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
